// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon absorb datapath.
//   STATE_W  - width of the full permutation state
//   RATE_W   - width of the rate lane x0 absorbed per block
//   PAD_BYTE - padding marker byte placed right after the message
//   state_e  - absorber control states
package ascon_pkg;

    localparam int unsigned STATE_W  = 320;
    localparam int unsigned RATE_W   = 64;
    localparam logic [7:0]  PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StWaitBlk,
        StPerm,
        StFinal,
        StOut
    } state_e;

endpackage

// File: rtl/ascon_pad.sv
// Combinational rate-block padding.
//   i_blk_data  - 64-bit block, byte 0 in bits [63:56]
//   i_blk_len   - number of valid bytes of a last block (0..7)
//   i_blk_last  - block is the final one; otherwise data passes through unchanged
//   o_blk_padded- block to XOR into x0
module ascon_pad
    import ascon_pkg::*;
(
    input  logic [RATE_W-1:0] i_blk_data,
    input  logic [2:0]        i_blk_len,
    input  logic              i_blk_last,
    output logic [RATE_W-1:0] o_blk_padded
);

    logic [5:0]        w_shift;
    logic [RATE_W-1:0] w_keep_mask;
    logic [RATE_W-1:0] w_pad_bits;

    // Byte count scaled to a bit shift; len=0 keeps nothing and pads byte 0.
    assign w_shift     = {i_blk_len, 3'b000};
    assign w_keep_mask = ~({RATE_W{1'b1}} >> w_shift);
    assign w_pad_bits  = {PAD_BYTE, {(RATE_W - 8){1'b0}}} >> w_shift;

    assign o_blk_padded = i_blk_last ? ((i_blk_data & w_keep_mask) | w_pad_bits) : i_blk_data;

endmodule

// File: rtl/ascon_absorber.sv
// Ascon absorb-phase controller: runs the initial permutation, XORs message
// blocks into x0 with intermediate permutations, pads and finalises the last
// block, and presents the final state through a valid/ready handshake.
//   i_init_state/i_init_valid/o_init_ready - start request with initial state
//   i_blk_*  /o_blk_ready                  - rate block stream
//   o_perm_state/o_perm_rounds/o_perm_start - request to permutation core
//   i_perm_out/i_perm_done                 - permutation core result
//   o_out_state/o_out_valid/i_out_ready    - final state handshake
module ascon_absorber
    import ascon_pkg::*;
#(
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [STATE_W-1:0] i_init_state,
    input  logic               i_init_valid,
    output logic               o_init_ready,
    input  logic [RATE_W-1:0]  i_blk_data,
    input  logic [2:0]         i_blk_len,
    input  logic               i_blk_last,
    input  logic               i_blk_valid,
    output logic               o_blk_ready,
    output logic [STATE_W-1:0] o_perm_state,
    output logic [4:0]         o_perm_rounds,
    output logic               o_perm_start,
    input  logic [STATE_W-1:0] i_perm_out,
    input  logic               i_perm_done,
    output logic [STATE_W-1:0] o_out_state,
    output logic               o_out_valid,
    input  logic               i_out_ready
);

    localparam logic [4:0] RND_A = 5'(ROUNDS_A);
    localparam logic [4:0] RND_B = 5'(ROUNDS_B);

    state_e             r_state,      w_state_d;
    logic [STATE_W-1:0] r_s,          w_s_d;
    logic [STATE_W-1:0] r_perm_state, w_perm_state_d;
    logic [4:0]         r_perm_rounds, w_perm_rounds_d;
    logic               r_perm_start, w_perm_start_d;
    logic [STATE_W-1:0] r_out_state,  w_out_state_d;
    logic               r_out_valid,  w_out_valid_d;
    logic [RATE_W-1:0]  w_blk_padded;

    ascon_pad u_pad (
        .i_blk_data   (i_blk_data),
        .i_blk_len    (i_blk_len),
        .i_blk_last   (i_blk_last),
        .o_blk_padded (w_blk_padded)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_s           <= '0;
            r_perm_state  <= '0;
            r_perm_rounds <= '0;
            r_perm_start  <= 1'b0;
            r_out_state   <= '0;
            r_out_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_s           <= w_s_d;
            r_perm_state  <= w_perm_state_d;
            r_perm_rounds <= w_perm_rounds_d;
            r_perm_start  <= w_perm_start_d;
            r_out_state   <= w_out_state_d;
            r_out_valid   <= w_out_valid_d;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_s_d           = r_s;
        w_perm_state_d  = r_perm_state;
        w_perm_rounds_d = r_perm_rounds;
        w_perm_start_d  = r_perm_start;
        w_out_state_d   = r_out_state;
        w_out_valid_d   = r_out_valid;

        case (r_state)
            StIdle: begin
                if (i_init_valid) begin
                    w_perm_state_d  = i_init_state;
                    w_perm_rounds_d = RND_A;
                    w_perm_start_d  = 1'b1;
                    w_state_d       = StInit;
                end
            end
            StInit, StPerm: begin
                if (i_perm_done) begin
                    w_s_d          = i_perm_out;
                    w_perm_start_d = 1'b0;
                    w_state_d      = StWaitBlk;
                end
            end
            StWaitBlk: begin
                if (i_blk_valid) begin
                    // Only x0 absorbs; the capacity lanes pass through untouched.
                    w_perm_state_d  = {r_s[STATE_W-1 -: RATE_W] ^ w_blk_padded,
                                       r_s[STATE_W-RATE_W-1:0]};
                    w_perm_rounds_d = i_blk_last ? RND_A : RND_B;
                    w_perm_start_d  = 1'b1;
                    w_state_d       = i_blk_last ? StFinal : StPerm;
                end
            end
            StFinal: begin
                if (i_perm_done) begin
                    w_out_state_d  = i_perm_out;
                    w_out_valid_d  = 1'b1;
                    w_perm_start_d = 1'b0;
                    w_state_d      = StOut;
                end
            end
            StOut: begin
                if (i_out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_state_d     = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_init_ready  = (r_state == StIdle);
    assign o_blk_ready   = (r_state == StWaitBlk);
    assign o_perm_state  = r_perm_state;
    assign o_perm_rounds = r_perm_rounds;
    assign o_perm_start  = r_perm_start;
    assign o_out_state   = r_out_state;
    assign o_out_valid   = r_out_valid;

endmodule
